// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronised, hold-stretched, staggered per-domain release plus optional run limit.
// Define RSTSEQ_WDOG_EN to add a RUN-state watchdog (WDOG_CYCLES, wdog_kick_i, wdog_fired_o).
module rst_seq_ctrl #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned HOLD_CYCLES    = 8,
  parameter int unsigned STAGGER_CYCLES = 2,
  parameter int unsigned RUN_LIMIT      = 50,
  parameter int unsigned CNT_W          = 16
`ifdef RSTSEQ_WDOG_EN
  ,
  parameter int unsigned WDOG_CYCLES    = 32
`endif
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sw_rst_req_i,
  input  logic              halt_clr_i,
`ifdef RSTSEQ_WDOG_EN
  input  logic              wdog_kick_i,
  output logic              wdog_fired_o,
`endif
  output logic [NUM_CH-1:0] ch_rst_o,
  output logic              all_released_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  run_cnt_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    StAssert  = 2'b00,
    StRelease = 2'b01,
    StRun     = 2'b10,
    StHalt    = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] StgLast  = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] RunLast  = CNT_W'(RUN_LIMIT - 1);

  logic [1:0] sync_q;
  logic       rst_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_sync = sync_q[1];

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   ch_rst_q, ch_rst_d, ch_shifted;
  logic                rel_q, rel_d;
  logic                halted_q, halted_d;
  logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0]    stg_q, stg_d;
  logic                release_step;
  logic                go_assert;
  logic                wdog_fire;

  // Domains release LSB first, so each release step is a left shift of the mask.
  assign ch_shifted = ch_rst_q << 1;

  always_comb begin
    state_d      = state_q;
    ch_rst_d     = ch_rst_q;
    rel_d        = rel_q;
    halted_d     = halted_q;
    run_cnt_d    = run_cnt_q;
    hold_d       = hold_q;
    stg_d        = stg_q;
    release_step = 1'b0;

    unique case (state_q)
      StAssert: begin
        if (hold_q == HoldLast) begin
          release_step = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StRelease: begin
        if (stg_q == StgLast) begin
          release_step = 1'b1;
        end else begin
          stg_d = stg_q + 1'b1;
        end
      end
      StRun: begin
        if (run_cnt_q != {CNT_W{1'b1}}) begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
        if ((RUN_LIMIT != 0) && (run_cnt_q == RunLast)) begin
          state_d   = StHalt;
          ch_rst_d  = '1;
          halted_d  = 1'b1;
          rel_d     = 1'b0;
          run_cnt_d = run_cnt_q;
        end
      end
      StHalt: begin
      end
      default: begin
      end
    endcase

    if (release_step) begin
      ch_rst_d = ch_shifted;
      hold_d   = '0;
      stg_d    = '0;
      if (ch_shifted == '0) begin
        state_d   = StRun;
        rel_d     = 1'b1;
        run_cnt_d = '0;
      end else begin
        state_d = StRelease;
      end
    end

    go_assert = !rst_sync || sw_rst_req_i || wdog_fire || ((state_q == StHalt) && halt_clr_i);
    if (go_assert) begin
      state_d   = StAssert;
      ch_rst_d  = '1;
      rel_d     = 1'b0;
      halted_d  = 1'b0;
      run_cnt_d = '0;
      hold_d    = '0;
      stg_d     = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StAssert;
      ch_rst_q  <= '1;
      rel_q     <= 1'b0;
      halted_q  <= 1'b0;
      run_cnt_q <= '0;
      hold_q    <= '0;
      stg_q     <= '0;
    end else begin
      state_q   <= state_d;
      ch_rst_q  <= ch_rst_d;
      rel_q     <= rel_d;
      halted_q  <= halted_d;
      run_cnt_q <= run_cnt_d;
      hold_q    <= hold_d;
      stg_q     <= stg_d;
    end
  end

`ifdef RSTSEQ_WDOG_EN
  localparam int unsigned      WdogW    = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYCLES - 1);

  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             fired_q, fired_d;

  assign wdog_fire = (state_q == StRun) && !wdog_kick_i && (wdog_q == WdogLast);

  always_comb begin
    wdog_d = '0;
    if ((state_q == StRun) && (state_d == StRun) && !wdog_kick_i) begin
      wdog_d = wdog_q + 1'b1;
    end
    // A simultaneous software request takes priority and does not count as a fire.
    fired_d = fired_q | (wdog_fire & rst_sync & ~sw_rst_req_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q  <= '0;
      fired_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      fired_q <= fired_d;
    end
  end

  assign wdog_fired_o = fired_q;
`else
  assign wdog_fire = 1'b0;
`endif

  assign ch_rst_o       = ch_rst_q;
  assign all_released_o = rel_q;
  assign halted_o       = halted_q;
  assign run_cnt_o      = run_cnt_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: expectations queued per clock edge, compared on the falling edge.
module tb_rst_seq_ctrl;

  logic clk;
  logic rst_n, rst_n_b;
  logic sw_a, clr_a, sw_b, clr_b;
  logic kick_on, kick_c;

  logic [3:0]  ch_a;
  logic        rel_a, halt_a;
  logic [15:0] run_a;
  logic [1:0]  st_a;

  logic [0:0]  ch_b;
  logic        rel_b, halt_b;
  logic [9:0]  run_b;
  logic [1:0]  st_b;

`ifdef RSTSEQ_WDOG_EN
  logic        fired_a, fired_b, fired_c;
  logic [3:0]  ch_c;
  logic        rel_c, halt_c;
  logic [15:0] run_c;
  logic [1:0]  st_c;
`endif

  rst_seq_ctrl u_dut_a (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .sw_rst_req_i  (sw_a),
    .halt_clr_i    (clr_a),
`ifdef RSTSEQ_WDOG_EN
    .wdog_kick_i   (kick_on),
    .wdog_fired_o  (fired_a),
`endif
    .ch_rst_o      (ch_a),
    .all_released_o(rel_a),
    .halted_o      (halt_a),
    .run_cnt_o     (run_a),
    .state_o       (st_a)
  );

  rst_seq_ctrl #(
    .NUM_CH        (1),
    .HOLD_CYCLES   (3),
    .STAGGER_CYCLES(1),
    .RUN_LIMIT     (0),
    .CNT_W         (10)
  ) u_dut_b (
    .clk_i         (clk),
    .rst_ni        (rst_n_b),
    .sw_rst_req_i  (sw_b),
    .halt_clr_i    (clr_b),
`ifdef RSTSEQ_WDOG_EN
    .wdog_kick_i   (kick_on),
    .wdog_fired_o  (fired_b),
`endif
    .ch_rst_o      (ch_b),
    .all_released_o(rel_b),
    .halted_o      (halt_b),
    .run_cnt_o     (run_b),
    .state_o       (st_b)
  );

`ifdef RSTSEQ_WDOG_EN
  rst_seq_ctrl #(
    .RUN_LIMIT  (0),
    .WDOG_CYCLES(32)
  ) u_dut_c (
    .clk_i         (clk),
    .rst_ni        (rst_n_b),
    .sw_rst_req_i  (sw_b),
    .halt_clr_i    (clr_b),
    .wdog_kick_i   (kick_c),
    .wdog_fired_o  (fired_c),
    .ch_rst_o      (ch_c),
    .all_released_o(rel_c),
    .halted_o      (halt_c),
    .run_cnt_o     (run_c),
    .state_o       (st_c)
  );
`endif

  typedef enum int {
    SelACh, SelASt, SelARel, SelAHalt, SelARun,
    SelBCh, SelBSt, SelBRel, SelBRun,
    SelCCh, SelCSt, SelCFired
  } sel_e;

  typedef struct {
    int          cyc;
    sel_e        sel;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  ecnt     = 0;
  int  e0       = 0;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input sel_e s);
    case (s)
      SelACh:    return 32'(ch_a);
      SelASt:    return 32'(st_a);
      SelARel:   return 32'(rel_a);
      SelAHalt:  return 32'(halt_a);
      SelARun:   return 32'(run_a);
      SelBCh:    return 32'(ch_b);
      SelBSt:    return 32'(st_b);
      SelBRel:   return 32'(rel_b);
      SelBRun:   return 32'(run_b);
`ifdef RSTSEQ_WDOG_EN
      SelCCh:    return 32'(ch_c);
      SelCSt:    return 32'(st_c);
      SelCFired: return 32'(fired_c);
`endif
      default:   return 32'hdead_beef;
    endcase
  endfunction

  task automatic push(input int c, input sel_e s, input logic [31:0] v);
    sb_t e;
    e.cyc = c;
    e.sel = s;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int t);
    int guard = 0;
    while (ecnt < t && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == ecnt) begin
        sel_e s;
        s = sb[i].sel;
        check($sformatf("%s@E%0d", s.name(), sb[i].cyc - e0), obs(s), sb[i].exp);
        sb.delete(i);
      end
    end
  end

`ifdef RSTSEQ_WDOG_EN
  initial begin
    int r;
    int k_last;
    kick_c = 1'b0;
    wait (e0 != 0);
    r      = e0 + 14;
    k_last = r + 100;
    push(r + 50, SelCSt, 2);
    push(k_last + 31, SelCSt, 2);
    push(k_last + 31, SelCFired, 0);
    push(k_last + 32, SelCSt, 0);
    push(k_last + 32, SelCFired, 1);
    push(k_last + 32, SelCCh, 4'hf);
    push(k_last + 60, SelCFired, 1);
    for (int k = 1; k <= 5; k++) begin
      wait_to(r + 20 * k - 1);
      kick_c = 1'b1;
      @(posedge clk);
      #1;
      kick_c = 1'b0;
    end
  end
`endif

  initial begin
    int c, x, e1, y, z;
    rst_n   = 1'b0;
    rst_n_b = 1'b0;
    sw_a    = 1'b0;
    clr_a   = 1'b0;
    sw_b    = 1'b0;
    clr_b   = 1'b0;
    kick_on = 1'b1;
    #195;
    rst_n   = 1'b1;
    rst_n_b = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    e0 = ecnt;

    // Power-on sequence and run limit on the default instance.
    push(e0, SelACh, 4'hf);       push(e0, SelASt, 0);
    push(e0 + 7, SelACh, 4'hf);   push(e0 + 7, SelASt, 0);
    push(e0 + 8, SelACh, 4'he);   push(e0 + 8, SelASt, 1);
    push(e0 + 10, SelACh, 4'hc);  push(e0 + 12, SelACh, 4'h8);
    push(e0 + 13, SelARel, 0);
    push(e0 + 14, SelACh, 4'h0);  push(e0 + 14, SelASt, 2);
    push(e0 + 14, SelARel, 1);    push(e0 + 14, SelARun, 0);
    push(e0 + 15, SelARun, 1);
    push(e0 + 63, SelARun, 49);   push(e0 + 63, SelASt, 2);
    push(e0 + 64, SelASt, 3);     push(e0 + 64, SelAHalt, 1);
    push(e0 + 64, SelACh, 4'hf);  push(e0 + 64, SelARel, 0);
    push(e0 + 66, SelARun, 49);

    // Single-domain, unlimited instance: release, long run, saturation.
    push(e0 + 2, SelBCh, 1);
    push(e0 + 3, SelBCh, 0);      push(e0 + 3, SelBSt, 2);
    push(e0 + 3, SelBRel, 1);     push(e0 + 3, SelBRun, 0);
    push(e0 + 1002, SelBRun, 999); push(e0 + 1002, SelBSt, 2);
    push(e0 + 1040, SelBRun, 1023); push(e0 + 1040, SelBSt, 2);

    wait_to(e0 + 66);
    clr_a = 1'b1;
    @(posedge clk);
    #1;
    c = ecnt;
    clr_a = 1'b0;
    push(c, SelASt, 0);           push(c, SelAHalt, 0);     push(c, SelACh, 4'hf);
    push(c + 7, SelACh, 4'hf);
    push(c + 8, SelACh, 4'he);    push(c + 8, SelASt, 1);
    push(c + 10, SelACh, 4'hc);

    wait_to(c + 11);
    sw_a = 1'b1;
    @(posedge clk);
    #1;
    x = ecnt;
    sw_a = 1'b0;
    check("sw_edge", 32'(x - c), 32'd12);
    push(x, SelACh, 4'hf);        push(x, SelASt, 0);       push(x, SelARel, 0);
    push(x + 7, SelACh, 4'hf);
    push(x + 8, SelACh, 4'he);    push(x + 8, SelASt, 1);
    push(x + 14, SelACh, 4'h0);   push(x + 14, SelASt, 2);  push(x + 14, SelARel, 1);
    push(x + 29, SelARun, 15);

    wait_to(x + 30);
    #5;
    rst_n = 1'b0;
    #1;
    check("async_ch", 32'(ch_a), 32'hf);
    check("async_run", 32'(run_a), 32'd0);
    check("async_rel", 32'(rel_a), 32'd0);
    check("async_st", 32'(st_a), 32'd0);
    #50;
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    e1 = ecnt;
    push(e1 + 7, SelACh, 4'hf);
    push(e1 + 8, SelACh, 4'he);
    push(e1 + 14, SelASt, 2);     push(e1 + 14, SelARel, 1);
    push(e1 + 64, SelASt, 3);     push(e1 + 64, SelAHalt, 1);

    // Software request and halt clear together in HALT, then request held high.
    wait_to(e1 + 65);
    sw_a  = 1'b1;
    clr_a = 1'b1;
    @(posedge clk);
    #1;
    y = ecnt;
    clr_a = 1'b0;
    push(y, SelASt, 0);           push(y, SelAHalt, 0);     push(y, SelACh, 4'hf);
    push(y + 5, SelASt, 0);       push(y + 5, SelACh, 4'hf);
    wait_to(y + 9);
    @(posedge clk);
    #1;
    z = ecnt;
    sw_a = 1'b0;
    push(z + 7, SelACh, 4'hf);    push(z + 7, SelASt, 0);
    push(z + 8, SelACh, 4'he);    push(z + 8, SelASt, 1);

    wait_to(e0 + 1041);
    check("sb_drain", 32'(sb.size()), 32'd0);
`ifdef RSTSEQ_WDOG_EN
    rst_n_b = 1'b0;
    #1;
    check("wdog_clr", 32'(fired_c), 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Parametrised clock-domain reset sequencer and run-limit controller for the openmips SOPC.
- Synchronises the board reset and stretches it by a programmable hold time.
- Releases NUM_CH reset domains (core, buses, ROM/RAM, peripherals) in staggered order.
- Optionally halts the system after a fixed run length by re-asserting all domain resets.

Parameters:
- NUM_CH, 4: number of reset domains (1..16).
- HOLD_CYCLES, 8: cycles all domains stay in reset after the synchronised release (>=1).
- STAGGER_CYCLES, 2: cycles between consecutive domain releases (>=1).
- RUN_LIMIT, 50: cycles in RUN before HALT; 0 = unlimited.
- CNT_W, 16: width of the hold, stagger and run counters. RUN_LIMIT and HOLD_CYCLES must fit in CNT_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- sw_rst_req  in  1  synchronous request to re-run the full sequence; level-sampled each cycle.
- halt_clr  in  1  synchronous; leaves HALT and resumes the sequence.
- ch_rst  out  NUM_CH  per-domain reset, active-high; bit k drives domain k.
- all_released  out  1  high only in RUN.
- halted  out  1  high only in HALT.
- run_cnt  out  CNT_W  cycles spent in RUN; saturates at all-ones.
- state  out  2  00 ASSERT, 01 RELEASE, 10 RUN, 11 HALT.

Behaviour:
- Reset synchroniser: a 2-flop synchroniser generates rst_sync.
  - Assertion is asynchronous: rst low immediately forces all outputs to their reset values.
  - Deassertion is synchronous: rst_sync goes high on the 2nd rising clk edge after rst rises.
- Reset values (rst low or rst_sync low): ch_rst all ones, all_released 0, halted 0, run_cnt 0, state ASSERT, all internal counters 0.
- Timing reference: E0 is the first rising edge on which rst_sync = 1. All registered outputs update on rising edges.
- ASSERT:
  - Hold counter increments each cycle.
  - At edge E0+HOLD_CYCLES: ch_rst[0] clears, state goes to RELEASE, stagger counter resets.
  - If NUM_CH = 1, go directly to RUN on that edge instead.
- RELEASE:
  - ch_rst[k] clears at edge E0+HOLD_CYCLES+k*STAGGER_CYCLES.
  - On the edge that clears ch_rst[NUM_CH-1]: state goes to RUN, all_released goes to 1, run_cnt goes to 0.
  - A cleared bit never re-asserts except on a transition back to ASSERT or HALT.
- RUN:
  - run_cnt increments every cycle after entry, saturating at 2^CNT_W-1.
  - If RUN_LIMIT != 0 and run_cnt == RUN_LIMIT-1, the next edge enters HALT.
- HALT:
  - ch_rst all ones, halted 1, all_released 0, run_cnt frozen.
  - halt_clr = 1 enters ASSERT with the hold counter cleared, i.e. the full hold/stagger sequence re-runs.
- sw_rst_req = 1 in any state: the next edge enters ASSERT with ch_rst all ones, all counters 0, halted 0 and all_released 0.
  - Held high, it keeps the block in ASSERT.
- Priority on the same edge: async rst > sw_rst_req > watchdog fire > halt_clr > run-limit > normal sequencing.
- rst going low mid-RELEASE or mid-RUN: ch_rst returns to all ones immediately, with no clock needed.
- No combinational path from any input to any output.

Optional Feature:
- Macro: RSTSEQ_WDOG_EN.
- Defined:
  - Adds parameter WDOG_CYCLES (default 32), input wdog_kick (1 bit) and output wdog_fired (1 bit, sticky).
  - In RUN, a watchdog counter clears on wdog_kick and otherwise increments.
  - On reaching WDOG_CYCLES-1 without a kick, the next edge enters ASSERT (as for sw_rst_req) and sets wdog_fired = 1.
  - wdog_fired clears only on async rst.
  - The watchdog counter is idle and 0 outside RUN.
- Undefined: no extra ports; behaviour exactly as above.

Test Plan:
- Power-on, defaults: rst low 195 ns, 50 MHz clk, rst rises -> ch_rst = 4'b1111 through E0+7; ch_rst = 4'b1110 at E0+8, 4'b1100 at E0+10, 4'b1000 at E0+12, 4'b0000 at E0+14; all_released = 1 and state = 10 at E0+14.
- Run limit: defaults, no requests -> run_cnt counts 0..49; at E0+64 state = 11, halted = 1, ch_rst = 4'b1111; halt_clr for 1 cycle -> state = 00 and the sequence repeats with the same offsets from the clear edge.
- sw_rst_req mid-RELEASE, pulsed at E0+11 -> at E0+12 ch_rst = 4'b1111 and state = 00; ch_rst[0] clears again 8 cycles later.
- Async reset mid-RUN: rst low between edges at E0+30 -> ch_rst = 4'b1111, run_cnt = 0 and all_released = 0 before the next edge.
- Simultaneous events: sw_rst_req and halt_clr both high in HALT -> state = 00, halted = 0; RUN_LIMIT = 0 run for 1000 cycles -> never halts, run_cnt = 1000 - 1 on the last RUN cycle observed.
- RSTSEQ_WDOG_EN, WDOG_CYCLES = 32: wdog_kick every 20 cycles -> stays in RUN; kicks stopped -> ASSERT after 32 idle cycles, wdog_fired = 1 until rst.
